// File: rtl/pulse_event_accumulator_pkg.sv
// Shared defaults, timer width and FSM state type for the pulse event accumulator.
package pulse_acc_pkg;

  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned BATCH_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 64;

  // Wide enough for the largest legal idle timeout (1023).
  localparam int unsigned IDLE_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCUM     = 2'd1,
    ST_FULL_WAIT = 2'd2
  } acc_state_e;

endpackage

// File: rtl/pulse_event_accumulator_if.sv
// Event/batch bundle between a pulse source/batch consumer (master) and the accumulator (slave).
interface pulse_event_accumulator_if
  import pulse_acc_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             pulse_in;
  logic             out_ready;
  logic             clr_ovf;
  logic             out_valid;
  logic [CNT_W-1:0] out_count;
  logic             out_timeout;
  logic             ovf;

  modport master (
    output pulse_in, out_ready, clr_ovf,
    input  out_valid, out_count, out_timeout, ovf
  );

  modport slave (
    input  pulse_in, out_ready, clr_ovf,
    output out_valid, out_count, out_timeout, ovf
  );
endinterface

// File: rtl/pulse_event_accumulator_idle_timer.sv
// Counts consecutive idle cycles of a non-empty partial batch; flags the TIMEOUT-th one.
module idle_timer
  import pulse_acc_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_b,
  input  logic rst_b,
  input  logic count_en,
  input  logic clear,
  output logic expired
);
  localparam logic [IDLE_W-1:0] LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] cnt_q;

  // Saturates so a flush blocked by a busy consumer keeps asserting until taken.
  assign expired = count_en && (cnt_q >= LAST);

  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + IDLE_W'(1);
    end
  end
endmodule

// File: rtl/pulse_event_accumulator.sv
// Counts single-cycle event pulses into batches and presents them on a valid/ready output.
// Optional partial-batch flush after TIMEOUT idle cycles is built with PULSE_ACC_TIMEOUT_EN.
module pulse_event_accumulator
  import pulse_acc_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned BATCH   = BATCH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk_b,
  input  logic                      rst_b,
  pulse_event_accumulator_if.slave  bus
);
  localparam logic [CNT_W-1:0] BATCH_V = CNT_W'(BATCH);

  if ((BATCH < 1) || (BATCH >= (1 << CNT_W)) || (TIMEOUT < 2) || (TIMEOUT > 1023)) begin : g_bad_cfg
    $error("pulse_event_accumulator: BATCH or TIMEOUT out of range");
  end

  acc_state_e       state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d, acc_inc;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic             ovf_q, ovf_d;
  logic             out_free, emit, drop, flush;

`ifdef PULSE_ACC_TIMEOUT_EN
  logic idle_cnt_en, idle_clr;

  assign idle_cnt_en = (acc_q != '0) && !bus.pulse_in;
  assign idle_clr    = bus.pulse_in || emit;

  idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk_b    (clk_b),
    .rst_b    (rst_b),
    .count_en (idle_cnt_en),
    .clear    (idle_clr),
    .expired  (flush)
  );
`else
  assign flush = 1'b0;
`endif

  // NOTE: every variable gets a default before any branch so no path can infer a latch.
  always_comb begin
    acc_d    = acc_q;
    count_d  = count_q;
    tmo_d    = tmo_q;
    valid_d  = valid_q;
    emit     = 1'b0;
    drop     = 1'b0;
    acc_inc  = acc_q + CNT_W'(1);
    out_free = !valid_q || bus.out_ready;

    if (valid_q && bus.out_ready) valid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (bus.pulse_in) begin
          if ((acc_inc == BATCH_V) && out_free) begin
            emit    = 1'b1;
            count_d = BATCH_V;
            tmo_d   = 1'b0;
            acc_d   = '0;
          end else begin
            acc_d = acc_inc;
          end
        end else if (flush && out_free) begin
          emit    = 1'b1;
          count_d = acc_q;
          tmo_d   = 1'b1;
          acc_d   = '0;
        end
      end
      ST_FULL_WAIT: begin
        // A pulse on the freeing edge opens the next batch instead of being lost.
        if (out_free) begin
          emit    = 1'b1;
          count_d = BATCH_V;
          tmo_d   = 1'b0;
          acc_d   = CNT_W'(bus.pulse_in);
        end else if (bus.pulse_in) begin
          drop = 1'b1;
        end
      end
      default: acc_d = '0;
    endcase

    if (emit) valid_d = 1'b1;

    ovf_d = drop ? 1'b1 : (bus.clr_ovf ? 1'b0 : ovf_q);

    if (acc_d == '0)          state_d = ST_IDLE;
    else if (acc_d == BATCH_V) state_d = ST_FULL_WAIT;
    else                       state_d = ST_ACCUM;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_count   = count_q;
  assign bus.out_timeout = tmo_q;
  assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_pulse_event_accumulator.sv
// Self-checking bench: phase table, directed corner sequences, and randomized run vs. a batch model.
module tb_pulse_event_accumulator;
  localparam int CNT_W   = 8;
  localparam int BATCH   = 16;
  localparam int TIMEOUT = 64;
`ifdef PULSE_ACC_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk_b = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk_b = ~clk_b;

  pulse_event_accumulator_if #(.CNT_W(CNT_W)) bus ();

  pulse_event_accumulator #(
    .CNT_W   (CNT_W),
    .BATCH   (BATCH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_b (clk_b),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending events, idle run length, presented batch, sticky drop flag.
  int m_pend, m_idle, m_pc;
  bit m_pv, m_pt, m_ovf;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input bit p, input bit r, input bit c);
    bit free, drop;
    free = !m_pv || r;
    drop = 1'b0;
    if (m_pv && r) m_pv = 1'b0;
    if (m_pend == BATCH) begin
      if (free) begin
        m_pv = 1'b1; m_pc = BATCH; m_pt = 1'b0;
        m_pend = p; m_idle = 0;
      end else if (p) begin
        drop = 1'b1;
      end
    end else if (p) begin
      m_pend++;
      m_idle = 0;
      if (m_pend == BATCH && free) begin
        m_pv = 1'b1; m_pc = BATCH; m_pt = 1'b0;
        m_pend = 0;
      end
    end else if (m_pend > 0) begin
      m_idle++;
      if (TMO_EN && m_idle >= TIMEOUT && free) begin
        m_pv = 1'b1; m_pc = m_pend; m_pt = 1'b1;
        m_pend = 0; m_idle = 0;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic cycle(input bit p, input bit r, input bit c);
    bus.pulse_in  = p;
    bus.out_ready = r;
    bus.clr_ovf   = c;
    model_step(p, r, c);
    @(posedge clk_b);
    #1;
  endtask

  task automatic model_clear();
    m_pend = 0; m_idle = 0; m_pc = 0;
    m_pv = 1'b0; m_pt = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    bus.pulse_in  = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    rst_b = 1'b1;
    model_clear();
    repeat (2) @(posedge clk_b);
    #1 rst_b = 1'b0;
    @(posedge clk_b);
    #1;
  endtask

  typedef struct {
    int cycles;
    bit pulse;
    bit ready;
    bit clr;
    bit exp_valid;
    int exp_count;
    bit exp_ovf;
  } phase_t;

  phase_t tbl[15];

  initial begin
    bit seen;
    int pulse_pct, ready_pct;

    // Phases from reset; count/timeout compared only when a batch is expected.
    tbl[0]  = '{15, 1, 1, 0, 0,  0, 0};
    tbl[1]  = '{ 1, 1, 1, 0, 1, 16, 0};
    tbl[2]  = '{16, 1, 0, 0, 1, 16, 0};
    tbl[3]  = '{ 1, 1, 0, 0, 1, 16, 1};
    tbl[4]  = '{ 1, 1, 1, 1, 1, 16, 0};
    tbl[5]  = '{14, 1, 1, 0, 0,  0, 0};
    tbl[6]  = '{ 1, 1, 0, 0, 1, 16, 0};
    tbl[7]  = '{ 3, 0, 0, 0, 1, 16, 0};
    tbl[8]  = '{ 1, 0, 1, 0, 0,  0, 0};
    tbl[9]  = '{16, 1, 0, 0, 1, 16, 0};
    tbl[10] = '{16, 1, 0, 0, 1, 16, 0};
    tbl[11] = '{ 1, 1, 0, 1, 1, 16, 1};
    tbl[12] = '{ 1, 0, 0, 1, 1, 16, 0};
    tbl[13] = '{ 1, 0, 1, 0, 1, 16, 0};
    tbl[14] = '{ 1, 0, 1, 0, 0,  0, 0};

    do_reset();
    check("reset_valid",   bus.out_valid,   0);
    check("reset_count",   bus.out_count,   0);
    check("reset_timeout", bus.out_timeout, 0);
    check("reset_ovf",     bus.ovf,         0);

    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < tbl[i].cycles; k++) cycle(tbl[i].pulse, tbl[i].ready, tbl[i].clr);
      check($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].exp_valid);
      check($sformatf("tbl%0d_ovf", i),   bus.ovf,       tbl[i].exp_ovf);
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d_count", i),   bus.out_count,   tbl[i].exp_count);
        check($sformatf("tbl%0d_timeout", i), bus.out_timeout, 0);
      end
    end

    // 16 pulses spaced 3 cycles apart with a ready consumer.
    do_reset();
    for (int i = 1; i <= BATCH; i++) begin
      cycle(1, 1, 0);
      if (i == BATCH - 1) check("spaced_15_valid", bus.out_valid, 0);
      if (i < BATCH) begin
        cycle(0, 1, 0);
        cycle(0, 1, 0);
      end
    end
    check("spaced_valid",   bus.out_valid,   1);
    check("spaced_count",   bus.out_count,   16);
    check("spaced_timeout", bus.out_timeout, 0);
    check("spaced_ovf",     bus.ovf,         0);
    cycle(0, 1, 0);
    check("spaced_accept", bus.out_valid, 0);

    // Stalled consumer, 40 back-to-back pulses.
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      cycle(1, 0, 0);
      if (i == 16) check("stall_first_valid", bus.out_valid, 1);
      if (i == 25) check("stall_hold_count",  bus.out_count, 16);
      if (i == 32) check("stall_ovf_32",      bus.ovf,       0);
      if (i == 33) check("stall_ovf_33",      bus.ovf,       1);
    end
    check("stall_valid_40", bus.out_valid, 1);
    check("stall_count_40", bus.out_count, 16);
    cycle(0, 1, 0);
    check("stall_second_valid", bus.out_valid, 1);
    check("stall_second_count", bus.out_count, 16);
    cycle(0, 1, 0);
    check("stall_drained", bus.out_valid, 0);
    check("stall_ovf_kept", bus.ovf, 1);
    cycle(0, 0, 1);
    check("stall_clr_ovf", bus.ovf, 0);

    // Five pulses then silence.
    do_reset();
    repeat (5) cycle(1, 1, 0);
    if (TMO_EN) begin
      repeat (63) cycle(0, 1, 0);
      check("tmo_before", bus.out_valid, 0);
      cycle(0, 1, 0);
      check("tmo_valid",   bus.out_valid,   1);
      check("tmo_count",   bus.out_count,   5);
      check("tmo_timeout", bus.out_timeout, 1);
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        cycle(0, 1, 0);
        if (bus.out_valid) seen = 1'b1;
      end
      check("no_flush_200", seen, 0);
    end

    // Pulse landing on the expiry cycle.
    do_reset();
    repeat (5) cycle(1, 1, 0);
    repeat (63) cycle(0, 1, 0);
    cycle(1, 1, 0);
    check("expiry_pulse_no_flush", bus.out_valid, 0);
    repeat (63) cycle(0, 1, 0);
    check("expiry_before", bus.out_valid, 0);
    cycle(0, 1, 0);
    if (TMO_EN) begin
      check("expiry_valid",   bus.out_valid,   1);
      check("expiry_count",   bus.out_count,   6);
      check("expiry_timeout", bus.out_timeout, 1);
    end else begin
      check("expiry_nomacro_valid", bus.out_valid, 0);
      repeat (10) cycle(1, 1, 0);
      check("expiry_nomacro_fill_valid", bus.out_valid, 1);
      check("expiry_nomacro_fill_count", bus.out_count, 16);
      check("expiry_nomacro_fill_tmo",   bus.out_timeout, 0);
    end

    // Asynchronous reset with a batch presented and 7 events pending.
    do_reset();
    repeat (33) cycle(1, 0, 0);
    cycle(0, 1, 0);
    repeat (7) cycle(1, 0, 0);
    check("pre_rst_valid", bus.out_valid, 1);
    check("pre_rst_ovf",   bus.ovf,       1);
    #2 rst_b = 1'b1;
    model_clear();
    #1;
    check("async_rst_valid",   bus.out_valid,   0);
    check("async_rst_count",   bus.out_count,   0);
    check("async_rst_timeout", bus.out_timeout, 0);
    check("async_rst_ovf",     bus.ovf,         0);
    #2 rst_b = 1'b0;
    repeat (15) cycle(1, 1, 0);
    check("post_rst_15_valid", bus.out_valid, 0);
    cycle(1, 1, 0);
    check("post_rst_valid", bus.out_valid, 1);
    check("post_rst_count", bus.out_count, 16);

    // Randomized traffic in segments of varying pulse density and consumer readiness.
    do_reset();
    for (int seg = 0; seg < 20; seg++) begin
      case ($urandom_range(0, 4))
        0: pulse_pct = 95;
        1: pulse_pct = 60;
        2: pulse_pct = 20;
        3: pulse_pct = 3;
        default: pulse_pct = 0;
      endcase
      case ($urandom_range(0, 3))
        0: ready_pct = 100;
        1: ready_pct = 70;
        2: ready_pct = 30;
        default: ready_pct = 5;
      endcase
      for (int i = 0; i < 200; i++) begin
        cycle($urandom_range(0, 99) < pulse_pct,
              $urandom_range(0, 99) < ready_pct,
              $urandom_range(0, 99) < 2);
        check("rnd_valid", bus.out_valid, m_pv);
        check("rnd_ovf",   bus.ovf,       m_ovf);
        if (m_pv) begin
          check("rnd_count",   bus.out_count,   m_pc);
          check("rnd_timeout", bus.out_timeout, m_pt);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
